// File: rtl/mem_access_pkg.sv
// ============================================================================
// mem_access_pkg : memop encodings, FSM state type and timeout default
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_access_pkg;

  localparam logic [1:0] MEMOP_WORD = 2'b00;
  localparam logic [1:0] MEMOP_HALF = 2'b01;
  localparam logic [1:0] MEMOP_BYTE = 2'b10;
  localparam logic [1:0] MEMOP_RSVD = 2'b11;

  localparam int unsigned DEFAULT_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } mau_state_t;

endpackage

`default_nettype wire

// File: rtl/load_store_lane.sv
// ============================================================================
// load_store_lane : byte-enable, store replication, load extract/extend
// Rev 1.0
// ============================================================================
`default_nettype none

module load_store_lane
  import mem_access_pkg::*;
(
  input  logic [1:0]  memop_i,
  input  logic [1:0]  off_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] bus_rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misaligned_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = bus_rdata_i[{off_i, 3'b000} +: 8];
  assign lane_h = off_i[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];

  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = wdata_i;
    rdata_o      = bus_rdata_i;
    misaligned_o = 1'b0;
    case (memop_i)
      MEMOP_WORD: begin
        be_o         = 4'b1111;
        misaligned_o = (off_i != 2'b00);
      end
      MEMOP_HALF: begin
        be_o         = off_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{wdata_i[15:0]}};
        rdata_o      = unsigned_i ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
        misaligned_o = off_i[0];
      end
      MEMOP_BYTE: begin
        be_o    = 4'b0001 << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = unsigned_i ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      default: misaligned_o = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// mem_access_unit : core load/store request to single-beat bus with timeout
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_memop,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam int unsigned    CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mau_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_valid_q, bus_we_q, err_q;
  logic [29:0]      bus_addr_q;
  logic [3:0]       bus_be_q;
  logic [31:0]      bus_wdata_q, rdata_q;
  logic [1:0]       lat_memop_q, lat_off_q;
  logic             lat_unsigned_q;

  logic             in_idle;
  logic [1:0]       lane_memop, lane_off;
  logic             lane_unsigned, lane_misaligned;
  logic [3:0]       lane_be;
  logic [31:0]      lane_wdata, lane_rdata;

  // In IDLE the lane decodes the live request; in ACCESS it uses the latched one
  assign in_idle       = (state_q == S_IDLE);
  assign lane_memop    = in_idle ? req_memop     : lat_memop_q;
  assign lane_off      = in_idle ? req_addr[1:0] : lat_off_q;
  assign lane_unsigned = in_idle ? req_unsigned  : lat_unsigned_q;

  load_store_lane u_lane (
    .memop_i     (lane_memop),
    .off_i       (lane_off),
    .unsigned_i  (lane_unsigned),
    .wdata_i     (req_wdata),
    .bus_rdata_i (bus_rdata),
    .be_o        (lane_be),
    .wdata_o     (lane_wdata),
    .rdata_o     (lane_rdata),
    .misaligned_o(lane_misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      bus_valid_q    <= 1'b0;
      bus_we_q       <= 1'b0;
      err_q          <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= '0;
      bus_wdata_q    <= '0;
      rdata_q        <= '0;
      lat_memop_q    <= '0;
      lat_off_q      <= '0;
      lat_unsigned_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            if (lane_misaligned) begin
              err_q   <= 1'b1;
              state_q <= S_RESP;
            end else begin
              bus_valid_q    <= 1'b1;
              bus_we_q       <= req_we;
              bus_addr_q     <= req_addr[31:2];
              bus_be_q       <= lane_be;
              bus_wdata_q    <= lane_wdata;
              lat_memop_q    <= req_memop;
              lat_off_q      <= req_addr[1:0];
              lat_unsigned_q <= req_unsigned;
              cnt_q          <= '0;
              err_q          <= 1'b0;
              state_q        <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          // A ready on the final allowed cycle still wins over the timeout
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            err_q       <= 1'b0;
            if (!bus_we_q) rdata_q <= lane_rdata;
            state_q     <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            bus_valid_q <= 1'b0;
            err_q       <= 1'b1;
            cnt_q       <= cnt_q + 1'b1;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign stall     = (in_idle & req_valid) | (state_q == S_ACCESS);
  assign done      = (state_q == S_RESP);
  assign err       = err_q;
  assign rdata     = rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_be    = bus_be_q;
  assign bus_wdata = bus_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// tb_mem_access_unit : directed + randomized bench against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we, req_unsigned;
  logic [1:0]  req_memop;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, err;
  logic [31:0] rdata;
  logic        bus_valid, bus_we;
  logic [29:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ready;
  logic [31:0] bus_rdata;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_rdata;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_memop(req_memop),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .err(err), .rdata(rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_misaligned(input logic [1:0] memop, input logic [31:0] addr);
    return (memop == 2'd3) || (memop == 2'd0 && addr % 4 != 0) || (memop == 2'd1 && addr % 2 != 0);
  endfunction

  function automatic logic [31:0] model_be(input logic [1:0] memop, input logic [31:0] addr);
    case (memop)
      2'd2:    return 32'h1 << (addr % 4);
      2'd1:    return 32'h3 << (2 * ((addr / 2) % 2));
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] memop, input logic [31:0] w);
    case (memop)
      2'd2:    return (w & 32'hFF) * 32'h01010101;
      2'd1:    return (w & 32'hFFFF) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] memop, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] v;
    case (memop)
      2'd2: begin
        v = (d >> (8 * (addr % 4))) & 32'hFF;
        if (!uns && v >= 32'h80) v = v - 32'h100;
      end
      2'd1: begin
        v = (d >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
        if (!uns && v >= 32'h8000) v = v - 32'h10000;
      end
      default: v = d;
    endcase
    return v;
  endfunction

  // delay = ACCESS cycles without ready before ready; >= TIMEOUT means never
  task automatic txn(input logic we, input logic [1:0] memop, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input int delay, input logic [31:0] brd, input logic keep);
    logic mis, eerr;
    int   acc, exp_acc;
    mis = model_misaligned(memop, addr);
    bus_ready = 1'b0;
    bus_rdata = brd;
    req_we = we; req_memop = memop; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1 check("idle_req_stall", 32'(stall), 32'd1);
    @(posedge clk); #1;
    if (mis) begin
      check("mis_bus_valid", 32'(bus_valid), 32'd0);
      check("mis_done", 32'(done), 32'd1);
      check("mis_err", 32'(err), 32'd1);
    end else begin
      acc = 0;
      while (bus_valid === 1'b1 && acc < TIMEOUT + 4) begin
        check("acc_bus_addr", 32'(bus_addr), addr >> 2);
        check("acc_bus_be", 32'(bus_be), model_be(memop, addr));
        check("acc_bus_we", 32'(bus_we), 32'(we));
        if (we) check("acc_bus_wdata", bus_wdata, model_wdata(memop, wdata));
        check("acc_stall", 32'(stall), 32'd1);
        check("acc_done", 32'(done), 32'd0);
        bus_ready = (acc == delay);
        @(posedge clk); #1;
        bus_ready = 1'b0;
        acc++;
      end
      exp_acc = (delay < TIMEOUT) ? delay + 1 : TIMEOUT;
      eerr    = (delay >= TIMEOUT);
      check("bus_valid_cycles", 32'(acc), 32'(exp_acc));
      check("resp_done", 32'(done), 32'd1);
      check("resp_err", 32'(err), 32'(eerr));
      if (!we && !eerr) model_rdata = model_load(memop, uns, addr, brd);
    end
    check("resp_stall", 32'(stall), 32'd0);
    check("resp_rdata", rdata, model_rdata);
    // Stray ready while the bus is idle must be ignored
    req_valid = keep;
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    check("idle_done", 32'(done), 32'd0);
    check("idle_bus_valid", 32'(bus_valid), 32'd0);
    check("idle_stall", 32'(stall), 32'(keep));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [1:0]  m;
    int          dly;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_memop = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b0; bus_rdata = '0;
    model_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_bus_we", 32'(bus_we), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'd0);
    check("rst_bus_be", 32'(bus_be), 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    txn(1'b1, 2'd0, 1'b0, 32'h104, 32'hDEADBEEF, 2, 32'h0, 1'b0);           // sw
    txn(1'b0, 2'd2, 1'b0, 32'h103, 32'h0, 1, 32'h80FF7F01, 1'b0);          // lb
    check("lb_value", rdata, 32'hFFFFFF80);
    txn(1'b0, 2'd2, 1'b1, 32'h103, 32'h0, 0, 32'h80FF7F01, 1'b0);          // lbu
    check("lbu_value", rdata, 32'h00000080);
    txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h0000ABCD, 1, 32'h0, 1'b0);          // sh
    txn(1'b0, 2'd1, 1'b0, 32'h101, 32'h0, 0, 32'h12345678, 1'b0);          // lh misaligned
    txn(1'b0, 2'd0, 1'b0, 32'h40, 32'h0, TIMEOUT + 5, 32'h55AA55AA, 1'b0); // lw timeout
    check("timeout_rdata_kept", rdata, 32'h00000080);
    txn(1'b0, 2'd0, 1'b0, 32'h44, 32'h0, TIMEOUT - 1, 32'hCAFEF00D, 1'b0); // ready on last cycle
    txn(1'b0, 2'd3, 1'b0, 32'h48, 32'h0, 0, 32'h0, 1'b0);                  // reserved memop
    txn(1'b0, 2'd0, 1'b0, 32'h80, 32'h0, 0, 32'h11223344, 1'b1);           // back-to-back lw
    txn(1'b1, 2'd0, 1'b0, 32'h84, 32'h99887766, 0, 32'h0, 1'b0);           // then sw

    // Reset in the second ACCESS cycle
    req_we = 1'b0; req_memop = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h300; req_valid = 1'b1; bus_ready = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_bus_valid", 32'(bus_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_acc_bus_valid", 32'(bus_valid), 32'd0);
    check("rst_acc_done", 32'(done), 32'd0);
    check("rst_acc_rdata", rdata, 32'd0);
    model_rdata = '0;
    txn(1'b0, 2'd1, 1'b1, 32'h200, 32'h0, 1, 32'h80018001, 1'b0);          // lhu
    check("lhu_value", rdata, 32'h00008001);

    for (int i = 0; i < 60; i++) begin
      m = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0:       dly = TIMEOUT;
        1:       dly = TIMEOUT - 1;
        default: dly = $urandom_range(0, 4);
      endcase
      txn(1'($urandom_range(0, 1)), m, 1'($urandom_range(0, 1)), $urandom, $urandom,
          dly, $urandom, (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
